// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe game sequencer: validates moves, drives the grid write port,
// alternates turns with an optional per-turn timeout, and reports win/draw.
module ttt_turn_controller #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TMR_W          = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  input  logic [17:0] board,
  output logic [3:0]  position,
  output logic        sel,
  output logic        pl,
  output logic        board_clr,
  output logic        turn,
  output logic        illegal,
  output logic        timeout,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_MOVE,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic             sel_q, sel_d;
  logic             pl_q, pl_d;
  logic             clr_q, clr_d;
  logic             turn_q, turn_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             over_q, over_d;
  logic [1:0]       winner_q, winner_d;
  logic [3:0]       moves_q, moves_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [1:0]  my_code;
  logic [15:0] empty_mask;
  logic [8:0]  mine;
  logic        line_win;
  logic        move_ok;
  logic        move_bad;
  logic        tmo_hit;

  // Player codes on the grid: player0 = 01, player1 = 10.
  assign my_code = {turn_q, ~turn_q};

  // Indices 9..15 read as occupied so out-of-range requests are rejected.
  assign empty_mask[15:9] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign empty_mask[gi] = (board[2*gi +: 2] == 2'b00);
      assign mine[gi]       = (board[2*gi +: 2] == my_code);
    end
  endgenerate

  assign line_win = (mine[0] & mine[1] & mine[2]) |
                    (mine[3] & mine[4] & mine[5]) |
                    (mine[6] & mine[7] & mine[8]) |
                    (mine[0] & mine[3] & mine[6]) |
                    (mine[1] & mine[4] & mine[7]) |
                    (mine[2] & mine[5] & mine[8]) |
                    (mine[0] & mine[4] & mine[8]) |
                    (mine[2] & mine[4] & mine[6]);

  assign move_ok  = move_valid && (move_pos <= 4'd8) && empty_mask[move_pos];
  assign move_bad = move_valid && !move_ok;
  assign tmo_hit  = TMO_EN && (timer_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    sel_d     = 1'b0;
    pl_d      = pl_q;
    clr_d     = 1'b0;
    turn_d    = turn_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    over_d    = over_q;
    winner_d  = winner_q;
    moves_d   = moves_q;
    timer_d   = timer_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr_d    = 1'b1;
          turn_d   = 1'b0;
          moves_d  = '0;
          timer_d  = '0;
          winner_d = 2'b00;
          over_d   = 1'b0;
          state_d  = S_WAIT_MOVE;
        end
      end
      S_WAIT_MOVE: begin
        timer_d = timer_q + 1'b1;
        if (move_ok) begin
          pos_d   = move_pos;
          sel_d   = 1'b1;
          pl_d    = turn_q;
          timer_d = '0;
          state_d = S_WRITE;
        end else begin
          // A rejected move and a timeout may both fire in the same cycle.
          illegal_d = move_bad;
          if (tmo_hit) begin
            timeout_d = 1'b1;
            turn_d    = ~turn_q;
            timer_d   = '0;
          end
        end
      end
      S_WRITE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        moves_d = moves_q + 4'd1;
        if (line_win) begin
          winner_d = my_code;
          over_d   = 1'b1;
          state_d  = S_DONE;
        end else if (moves_q + 4'd1 == 4'd9) begin
          winner_d = 2'b11;
          over_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_WAIT_MOVE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      sel_q     <= 1'b0;
      pl_q      <= 1'b0;
      clr_q     <= 1'b0;
      turn_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 2'b00;
      moves_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      sel_q     <= sel_d;
      pl_q      <= pl_d;
      clr_q     <= clr_d;
      turn_q    <= turn_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      moves_q   <= moves_d;
      timer_q   <= timer_d;
    end
  end

  assign position  = pos_q;
  assign sel       = sel_q;
  assign pl        = pl_q;
  assign board_clr = clr_q;
  assign turn      = turn_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign game_over = over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Bench for ttt_turn_controller: a behavioural play grid plus cycle-by-cycle
// vector tables checked through an expectation queue.
module tb_ttt_turn_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        move_valid;
  logic [3:0]  move_pos;
  logic [17:0] board;
  logic [3:0]  position;
  logic        sel;
  logic        pl;
  logic        board_clr;
  logic        turn;
  logic        illegal;
  logic        timeout;
  logic        game_over;
  logic [1:0]  winner;

  ttt_turn_controller #(
    .TIMEOUT_CYCLES(8),
    .TMR_W         (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .move_valid(move_valid),
    .move_pos  (move_pos),
    .board     (board),
    .position  (position),
    .sel       (sel),
    .pl        (pl),
    .board_clr (board_clr),
    .turn      (turn),
    .illegal   (illegal),
    .timeout   (timeout),
    .game_over (game_over),
    .winner    (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Play grid: written on sel, cleared by its reset or by board_clr.
  logic [17:0] grid_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grid_q <= '0;
    end else if (board_clr) begin
      grid_q <= '0;
    end else if (sel) begin
      for (int k = 0; k < 9; k++) begin
        if (position == 4'(k)) grid_q[2*k +: 2] <= pl ? 2'b10 : 2'b01;
      end
    end
  end
  assign board = board_clr ? 18'd0 : grid_q;

  // Expected outputs packed as {sel, position, pl, board_clr, turn, illegal, timeout, game_over, winner}.
  typedef struct {
    logic        st;
    logic        mv;
    logic [3:0]  pos;
    logic [12:0] exp;
    string       tag;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb[$];
  string       cur_tag;
  int          n_vec;
  int          n_bad;

  function automatic logic [12:0] ex(input logic e_sel, input logic [3:0] e_pos, input logic e_pl,
                                      input logic e_clr, input logic e_turn, input logic e_ill,
                                      input logic e_to, input logic e_go, input logic [1:0] e_win);
    return {e_sel, e_pos, e_pl, e_clr, e_turn, e_ill, e_to, e_go, e_win};
  endfunction

  task automatic add(input logic st, input logic mv, input logic [3:0] p, input logic [12:0] e);
    vec_t v;
    v.st  = st;
    v.mv  = mv;
    v.pos = p;
    v.exp = e;
    v.tag = cur_tag;
    vecs.push_back(v);
  endtask

  // One accepted move: WRITE cycle, CHECK cycle, then next turn or game end.
  task automatic play(input logic [3:0] p, input logic t, input logic [1:0] w);
    add(1'b0, 1'b1, p,    ex(1'b1, p, t, 1'b0, t, 1'b0, 1'b0, 1'b0, 2'b00));
    add(1'b0, 1'b0, 4'd0, ex(1'b0, p, t, 1'b0, t, 1'b0, 1'b0, 1'b0, 2'b00));
    if (w == 2'b00)
      add(1'b0, 1'b0, 4'd0, ex(1'b0, p, t, 1'b0, ~t, 1'b0, 1'b0, 1'b0, 2'b00));
    else
      add(1'b0, 1'b0, 4'd0, ex(1'b0, p, t, 1'b0, t, 1'b0, 1'b0, 1'b1, w));
  endtask

  task automatic check(input string name, input int idx);
    logic [12:0] act;
    logic [12:0] want;
    act = {sel, position, pl, board_clr, turn, illegal, timeout, game_over, winner};
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b, no expectation queued", name, idx, act);
      return;
    end
    want = sb.pop_front();
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got sel/pos/pl/clr/turn/ill/to/go/win=%b want %b", name, idx, act, want);
    end else begin
      $display("%s[%0d] ok out=%b", name, idx, act);
    end
  endtask

  task automatic step(input logic st, input logic mv, input logic [3:0] p,
                      input logic [12:0] e, input string name, input int idx);
    start      = st;
    move_valid = mv;
    move_pos   = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name, idx);
  endtask

  logic [3:0] draw_seq [9];

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    move_valid = 1'b0;
    move_pos   = 4'd0;
    draw_seq   = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

    // Game 1: P0 wins on the top row, with rejected moves mid-game.
    cur_tag = "win";
    add(1'b1, 1'b0, 4'd0, ex(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    play(4'd0, 1'b0, 2'b00);
    play(4'd3, 1'b1, 2'b00);
    play(4'd1, 1'b0, 2'b00);
    play(4'd4, 1'b1, 2'b00);
    cur_tag = "illegal";
    add(1'b0, 1'b1, 4'd4,  ex(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
    add(1'b0, 1'b1, 4'd9,  ex(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
    add(1'b0, 1'b1, 4'd0,  ex(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
    add(1'b0, 1'b1, 4'd15, ex(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
    add(1'b0, 1'b0, 4'd0,  ex(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    cur_tag = "win";
    play(4'd2, 1'b0, 2'b01);
    cur_tag = "done_hold";
    add(1'b0, 1'b1, 4'd5, ex(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01));
    add(1'b0, 1'b0, 4'd0, ex(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01));

    // Game 2: restart from DONE, then a full board with no line.
    cur_tag = "restart";
    add(1'b1, 1'b0, 4'd0, ex(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    add(1'b1, 1'b0, 4'd0, ex(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    cur_tag = "draw";
    for (int k = 0; k < 9; k++)
      play(draw_seq[k], 1'(k % 2), (k == 8) ? 2'b11 : 2'b00);

    // Game 3: turn timeout after eight idle cycles, a move on the timeout cycle,
    // and a rejected move coinciding with a timeout.
    cur_tag = "timeout";
    add(1'b1, 1'b0, 4'd0, ex(1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    for (int k = 0; k < 7; k++)
      add(1'b0, 1'b0, 4'd0, ex(1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    add(1'b0, 1'b0, 4'd0, ex(1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00));
    for (int k = 0; k < 7; k++)
      add(1'b0, 1'b0, 4'd0, ex(1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    cur_tag = "move_beats_timeout";
    play(4'd4, 1'b1, 2'b00);
    cur_tag = "illegal_with_timeout";
    for (int k = 0; k < 7; k++)
      add(1'b0, 1'b0, 4'd0, ex(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    add(1'b0, 1'b1, 4'd4, ex(1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00));
    add(1'b0, 1'b0, 4'd0, ex(1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));

    // Reset state.
    @(posedge clk);
    #1;
    sb.push_back(13'd0);
    check("reset", 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].st, vecs[i].mv, vecs[i].pos, vecs[i].exp, vecs[i].tag, i);

    // Asynchronous reset while a move is being written, then a clean game.
    step(1'b0, 1'b1, 4'd0, ex(1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00), "rst_write", 0);
    rst = 1'b0;
    #1;
    sb.push_back(13'd0);
    check("rst_write", 1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 4'd0, ex(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), "rst_write", 2);
    step(1'b0, 1'b1, 4'd4, ex(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), "rst_write", 3);
    step(1'b0, 1'b0, 4'd0, ex(1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), "rst_write", 4);
    step(1'b0, 1'b0, 4'd0, ex(1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00), "rst_write", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
